snoop_responder: RTL and testbench

// - Responder side of the MESI snoop bus protocol; the cache is the initiator.
// - Accepts one bus op snooped from another agent and looks up the local tag array (combinational port).
// - Posts a snoop result, fetches dirty data from L1 and writes it back on a HITM, and invalidates L1 where required.
// - Commits the new MESI state. Sits beside the cache, between the system bus and the tag/LRU array.

---
 rtl/snoop_responder_pkg.sv | 25 ++
 rtl/snoop_responder_next_state.sv | 60 ++++++
 rtl/snoop_responder.sv | 143 ++++++++++++++
 tb/tb_snoop_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_responder_pkg.sv
// rtl/snoop_responder_pkg.sv - shared types, FSM encodings and width helpers for the snoop responder
package snoop_responder_pkg;

    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVALIDATE = 2'd2, OP_RWIM = 2'd3} bus_op_t;
    typedef enum logic [1:0] {NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2} snoop_result_t;
    typedef enum logic [1:0] {GETLINE = 2'd0, INVALIDATELINE = 2'd1} l2_l1_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_RESULT    = 3'd2;
    localparam logic [2:0] ST_GETLINE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_INVAL     = 3'd5;
    localparam logic [2:0] ST_UPDATE    = 3'd6;

    function automatic int idx_width(input int c_size, input int a_size, input int d_size);
        return c_size - $clog2(a_size) - d_size;
    endfunction

    function automatic int tag_width(input int i_size, input int idx_w, input int d_size);
        return i_size - idx_w - d_size;
    endfunction

endpackage

// File: rtl/snoop_responder_next_state.sv
// rtl/snoop_responder_next_state.sv - combinational MESI snoop table: op and current state to result, next state, actions
module snoop_next_state
    import snoop_responder_pkg::*;
(
    input  bus_op_t       op_i,
    input  logic          hit_i,
    input  mesi_t         mesi_i,
    output snoop_result_t result_o,
    output mesi_t         next_o,
    output logic          need_get_o,
    output logic          need_inv_o,
    output logic          err_o
);

    logic hit_eff;
    assign hit_eff = hit_i && (mesi_i != MESI_I);

    always_comb begin
        result_o   = NOHIT;
        next_o     = hit_eff ? mesi_i : MESI_I;
        need_get_o = 1'b0;
        need_inv_o = 1'b0;
        err_o      = 1'b0;
        if (hit_eff) begin
            case (op_i)
                OP_READ: begin
                    next_o = MESI_S;
                    if (mesi_i == MESI_M) begin
                        result_o   = HITM;
                        need_get_o = 1'b1;
                    end else begin
                        result_o = HIT;
                    end
                end
                OP_RWIM: begin
                    next_o     = MESI_I;
                    need_inv_o = 1'b1;
                    if (mesi_i == MESI_M) begin
                        result_o   = HITM;
                        need_get_o = 1'b1;
                    end else begin
                        result_o = HIT;
                    end
                end
                OP_INVALIDATE: begin
                    // Another agent cannot invalidate a line we own exclusively.
                    if (mesi_i == MESI_S) begin
                        result_o   = HIT;
                        next_o     = MESI_I;
                        need_inv_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MESI snoop responder: lookup, result, L1 fetch/writeback, L1 invalidate, state commit
module snoop_responder
    import snoop_responder_pkg::*;
#(
    parameter int  I_SIZE   = 32,
    parameter int  C_SIZE   = 24,
    parameter int  D_SIZE   = 6,
    parameter int  A_SIZE   = 8,
    parameter int  PROTOCOL = 2,
    localparam int IDX_W    = idx_width(C_SIZE, A_SIZE, D_SIZE),
    localparam int TAG_W    = tag_width(I_SIZE, IDX_W, D_SIZE),
    localparam int WAY_W    = $clog2(A_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                snoop_valid,
    output logic                snoop_ready,
    input  logic [1:0]          snoop_op,
    input  logic [I_SIZE-1:0]   snoop_addr,
    output logic [IDX_W-1:0]    lk_index,
    output logic [TAG_W-1:0]    lk_tag,
    input  logic                lk_hit,
    input  logic [WAY_W-1:0]    lk_way,
    input  logic [PROTOCOL-1:0] lk_mesi,
    output logic                result_valid,
    output logic [1:0]          snoop_result,
    output logic                l2_l1_valid,
    output logic [1:0]          l2_l1,
    input  logic                l2_l1_ack,
    output logic                wb_valid,
    output logic [1:0]          wb_op,
    output logic [I_SIZE-1:0]   wb_addr,
    input  logic                wb_ack,
    output logic                upd_valid,
    output logic [IDX_W-1:0]    upd_index,
    output logic [WAY_W-1:0]    upd_way,
    output logic [PROTOCOL-1:0] upd_mesi,
    output logic                protocol_err
);

    logic [2:0]             state_q, state_d;
    bus_op_t                op_q;
    logic [I_SIZE-1:D_SIZE] line_q;
    logic [WAY_W-1:0]       way_q;
    mesi_t                  cur_q, next_q;
    snoop_result_t          result_q;
    logic                   get_q, inv_q, err_q;

    snoop_result_t          tbl_result;
    mesi_t                  tbl_next;
    mesi_t                  lk_cur;
    logic                   tbl_get, tbl_inv, tbl_err;
    logic                   change;

    // Line offset bits are irrelevant to a snoop.
    logic unused_offset;
    assign unused_offset = ^snoop_addr[D_SIZE-1:0];

    assign lk_cur = lk_hit ? mesi_t'(lk_mesi) : MESI_I;
    assign change = (next_q != cur_q);

    snoop_next_state u_table (
        .op_i       (op_q),
        .hit_i      (lk_hit),
        .mesi_i     (lk_cur),
        .result_o   (tbl_result),
        .next_o     (tbl_next),
        .need_get_o (tbl_get),
        .need_inv_o (tbl_inv),
        .err_o      (tbl_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (snoop_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:    state_d = ST_RESULT;
            ST_RESULT: begin
                if (get_q)       state_d = ST_GETLINE;
                else if (inv_q)  state_d = ST_INVAL;
                else if (change) state_d = ST_UPDATE;
                else             state_d = ST_IDLE;
            end
            ST_GETLINE:   if (l2_l1_ack) state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (wb_ack) begin
                    if (inv_q)       state_d = ST_INVAL;
                    else if (change) state_d = ST_UPDATE;
                    else             state_d = ST_IDLE;
                end
            end
            ST_INVAL:     if (l2_l1_ack) state_d = change ? ST_UPDATE : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            line_q   <= '0;
            way_q    <= '0;
            cur_q    <= MESI_I;
            next_q   <= MESI_I;
            result_q <= NOHIT;
            get_q    <= 1'b0;
            inv_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && snoop_valid) begin
                op_q   <= bus_op_t'(snoop_op);
                line_q <= snoop_addr[I_SIZE-1:D_SIZE];
            end
            if (state_q == ST_LOOKUP) begin
                way_q    <= lk_way;
                cur_q    <= lk_cur;
                next_q   <= tbl_next;
                result_q <= tbl_result;
                get_q    <= tbl_get;
                inv_q    <= tbl_inv;
                err_q    <= tbl_err;
            end
        end
    end

    assign snoop_ready  = (state_q == ST_IDLE) && !reset;
    assign lk_index     = line_q[D_SIZE +: IDX_W];
    assign lk_tag       = line_q[D_SIZE+IDX_W +: TAG_W];
    assign result_valid = (state_q == ST_RESULT);
    assign snoop_result = result_q;
    assign protocol_err = (state_q == ST_RESULT) && err_q;
    assign l2_l1_valid  = (state_q == ST_GETLINE) || (state_q == ST_INVAL);
    assign l2_l1        = (state_q == ST_INVAL) ? INVALIDATELINE : GETLINE;
    assign wb_valid     = (state_q == ST_WRITEBACK);
    assign wb_op        = wb_valid ? OP_WRITE : OP_READ;
    assign wb_addr      = wb_valid ? {line_q, {D_SIZE{1'b0}}} : '0;
    assign upd_valid    = (state_q == ST_UPDATE);
    assign upd_index    = lk_index;
    assign upd_way      = way_q;
    assign upd_mesi     = next_q;

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - scoreboard bench for snoop_responder
module tb_snoop_responder;
    import snoop_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [1:0]  snoop_op;
    logic [31:0] snoop_addr;
    logic [14:0] lk_index;
    logic [10:0] lk_tag;
    logic        lk_hit;
    logic [2:0]  lk_way;
    logic [1:0]  lk_mesi;
    logic        result_valid;
    logic [1:0]  snoop_result;
    logic        l2_l1_valid;
    logic [1:0]  l2_l1;
    logic        l2_l1_ack;
    logic        wb_valid;
    logic [1:0]  wb_op;
    logic [31:0] wb_addr;
    logic        wb_ack;
    logic        upd_valid;
    logic [14:0] upd_index;
    logic [2:0]  upd_way;
    logic [1:0]  upd_mesi;
    logic        protocol_err;

    always #5 clk = ~clk;

    snoop_responder dut (
        .clk(clk), .reset(reset),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .lk_index(lk_index), .lk_tag(lk_tag), .lk_hit(lk_hit), .lk_way(lk_way), .lk_mesi(lk_mesi),
        .result_valid(result_valid), .snoop_result(snoop_result),
        .l2_l1_valid(l2_l1_valid), .l2_l1(l2_l1), .l2_l1_ack(l2_l1_ack),
        .wb_valid(wb_valid), .wb_op(wb_op), .wb_addr(wb_addr), .wb_ack(wb_ack),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
        .protocol_err(protocol_err)
    );

    localparam int K_RES = 0, K_ERR = 1, K_L2 = 2, K_WB = 3, K_UPD = 4;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        bus_op_t       op;
        logic          hit;
        mesi_t         mesi;
        logic [2:0]    way;
        logic [31:0]   addr;
        snoop_result_t res;
        logic          err;
        logic          get;
        logic          inv;
        logic          upd;
        mesi_t         nxt;
        logic [14:0]   idx;
        logic [31:0]   wba;
        int            lat;
        int            l2_dly;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   t_acc2;
    int   l2_delay = 0;
    int   l2_cnt = 0;
    bit   wb_auto = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic chk_evt(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=0x%0h required=none", kind, a);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("evt%0d_kind", kind), kind, e.kind);
            check($sformatf("evt%0d_a", kind), a, e.a);
            check($sformatf("evt%0d_b", kind), b, e.b);
        end
    endtask

    // Monitor: every observed output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (result_valid) chk_evt(K_RES, {30'd0, snoop_result}, 0);
            if (protocol_err) chk_evt(K_ERR, 0, 0);
            if (l2_l1_valid && l2_l1_ack) chk_evt(K_L2, {30'd0, l2_l1}, 0);
            if (wb_valid && wb_ack) chk_evt(K_WB, wb_addr, {30'd0, wb_op});
            if (upd_valid) chk_evt(K_UPD, {17'd0, upd_index}, {27'd0, upd_way, upd_mesi});
        end
    end

    initial begin
        l2_l1_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (l2_l1_valid && !l2_l1_ack) begin
                if (l2_cnt >= l2_delay) begin
                    l2_l1_ack = 1'b1;
                    l2_cnt = 0;
                end else begin
                    l2_cnt++;
                end
            end else begin
                l2_l1_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (wb_auto) wb_ack = wb_valid && !wb_ack;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input bus_op_t op, input logic [31:0] addr);
        @(posedge clk); #1;
        snoop_valid = 1'b1;
        snoop_op    = op;
        snoop_addr  = addr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (snoop_ready) break;
        end
        @(posedge clk); #1;
        snoop_valid = 1'b0;
        t_acc = cyc - 1;
    endtask

    task automatic wait_ready(input int exp_lat, input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (snoop_ready) break;
        end
        check(name, snoop_ready ? cyc - t_acc : -1, exp_lat);
    endtask

    initial begin
        reset = 1'b1; snoop_valid = 1'b0; snoop_op = 2'd0; snoop_addr = 32'd0;
        lk_hit = 1'b0; lk_way = 3'd0; lk_mesi = 2'd0; wb_ack = 1'b0;

        // Reset held two cycles; outputs idle throughout.
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("rst_ready", snoop_ready, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_l2_l1_valid", l2_l1_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_lk_index", lk_index, 0);
        check("rst_wb_addr", wb_addr, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", snoop_ready, 1);

        vecs.push_back('{OP_READ,       1'b1, MESI_E, 3'd3, 32'h12345678, HIT,   1'b0, 1'b0, 1'b0, 1'b1, MESI_S, 15'h5159, 32'h0,        4, 0});
        vecs.push_back('{OP_INVALIDATE, 1'b1, MESI_E, 3'd3, 32'h12345678, NOHIT, 1'b1, 1'b0, 1'b0, 1'b0, MESI_E, 15'h5159, 32'h0,        3, 0});
        vecs.push_back('{OP_READ,       1'b1, MESI_S, 3'd1, 32'h00001FC0, HIT,   1'b0, 1'b0, 1'b0, 1'b0, MESI_S, 15'h007F, 32'h0,        3, 0});
        vecs.push_back('{OP_WRITE,      1'b1, MESI_M, 3'd0, 32'h12345678, NOHIT, 1'b1, 1'b0, 1'b0, 1'b0, MESI_M, 15'h5159, 32'h0,        3, 0});
        vecs.push_back('{OP_INVALIDATE, 1'b1, MESI_S, 3'd7, 32'hFFFFFFFF, HIT,   1'b0, 1'b0, 1'b1, 1'b1, MESI_I, 15'h7FFF, 32'h0,        5, 0});
        vecs.push_back('{OP_RWIM,       1'b1, MESI_E, 3'd2, 32'h00001FC0, HIT,   1'b0, 1'b0, 1'b1, 1'b1, MESI_I, 15'h007F, 32'h0,        5, 0});
        vecs.push_back('{OP_READ,       1'b1, MESI_M, 3'd6, 32'hABCDEF7F, HITM,  1'b0, 1'b1, 1'b0, 1'b1, MESI_S, 15'h37BD, 32'hABCDEF40, 6, 0});
        vecs.push_back('{OP_RWIM,       1'b0, MESI_I, 3'd0, 32'h12345678, NOHIT, 1'b0, 1'b0, 1'b0, 1'b0, MESI_I, 15'h5159, 32'h0,        3, 0});
        vecs.push_back('{OP_RWIM,       1'b1, MESI_M, 3'd5, 32'h12345678, HITM,  1'b0, 1'b1, 1'b1, 1'b1, MESI_I, 15'h5159, 32'h12345640, 11, 2});

        foreach (vecs[i]) begin
            lk_hit = vecs[i].hit; lk_way = vecs[i].way; lk_mesi = vecs[i].mesi;
            l2_delay = vecs[i].l2_dly;
            push(K_RES, {30'd0, vecs[i].res}, 0);
            if (vecs[i].err) push(K_ERR, 0, 0);
            if (vecs[i].get) begin
                push(K_L2, {30'd0, GETLINE}, 0);
                push(K_WB, vecs[i].wba, {30'd0, OP_WRITE});
            end
            if (vecs[i].inv) push(K_L2, {30'd0, INVALIDATELINE}, 0);
            if (vecs[i].upd) push(K_UPD, {17'd0, vecs[i].idx}, {27'd0, vecs[i].way, vecs[i].nxt});
            issue(vecs[i].op, vecs[i].addr);
            @(negedge clk);
            check($sformatf("v%0d_lk_index", i), lk_index, vecs[i].idx);
            check($sformatf("v%0d_busy", i), snoop_ready, 0);
            if (i == 0) check("v0_lk_tag", lk_tag, 11'h091);
            wait_ready(vecs[i].lat, $sformatf("v%0d_latency", i));
        end
        l2_delay = 0;

        // Second op held while busy is accepted only when the responder returns to idle.
        lk_hit = 1'b0; lk_mesi = 2'd0;
        push(K_RES, {30'd0, NOHIT}, 0);
        push(K_RES, {30'd0, NOHIT}, 0);
        issue(OP_READ, 32'h12345678);
        snoop_valid = 1'b1; snoop_op = OP_READ; snoop_addr = 32'h00001FC0;
        @(negedge clk);
        check("busy_lk_index_t1", lk_index, 15'h5159);
        @(negedge clk);
        check("busy_lk_index_t2", lk_index, 15'h5159);
        wait_ready(3, "held_op_ready");
        @(posedge clk); #1;
        snoop_valid = 1'b0;
        t_acc2 = cyc - 1;
        check("held_op_accept_cycle", t_acc2 - t_acc, 3);
        t_acc = t_acc2;
        @(negedge clk);
        check("held_op_lk_index", lk_index, 15'h007F);
        wait_ready(3, "held_op_latency");

        // Reset during writeback aborts: no writeback completion, no update, late ack ignored.
        wb_auto = 1'b0; wb_ack = 1'b0;
        lk_hit = 1'b1; lk_way = 3'd5; lk_mesi = MESI_M;
        push(K_RES, {30'd0, HITM}, 0);
        push(K_L2, {30'd0, GETLINE}, 0);
        issue(OP_RWIM, 32'h12345678);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wb_valid) break;
        end
        check("abort_reached_wb", wb_valid, 1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("abort_wb_valid_low", wb_valid, 0);
        check("abort_ready", snoop_ready, 1);
        @(posedge clk); #1; wb_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_wb_valid", wb_valid, 0);
            check("late_ack_upd_valid", upd_valid, 0);
            check("late_ack_ready", snoop_ready, 1);
        end
        @(posedge clk); #1; wb_ack = 1'b0; wb_auto = 1'b1;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
